// File: rtl/dmux2_stream.sv
//------------------------------------------------------------------------------
// Module      : dmux2_stream
// Description : Registered 1:2 stream demultiplexer with valid/ready holding
//               slots, s0 or round-robin steering, per-channel word counters.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dmux2_stream #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         mode,
  input  logic         s0,
  input  logic [W-1:0] d0,
  input  logic         d0_valid,
  output logic         d0_ready,
  output logic [W-1:0] z0,
  output logic [W-1:0] z1,
  output logic         z0_valid,
  output logic         z1_valid,
  input  logic         z0_ready,
  input  logic         z1_ready,
  output logic [7:0]   cnt0,
  output logic [7:0]   cnt1
);

  logic [W-1:0] r_z0;
  logic [W-1:0] r_z1;
  logic         r_v0;
  logic         r_v1;
  logic         r_rr;
  logic [7:0]   r_cnt0;
  logic [7:0]   r_cnt1;

  logic w_t;
  logic w_drain0;
  logic w_drain1;
  logic w_ready;
  logic w_acc0;
  logic w_acc1;

  assign w_t      = mode ? r_rr : s0;
  assign w_drain0 = r_v0 & z0_ready;
  assign w_drain1 = r_v1 & z1_ready;
  // Only the targeted slot gates the input; the other slot may stay full.
  assign w_ready  = w_t ? (~r_v1 | z1_ready) : (~r_v0 | z0_ready);
  assign w_acc0   = d0_valid & w_ready & ~w_t;
  assign w_acc1   = d0_valid & w_ready &  w_t;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_z0   <= '0;
      r_z1   <= '0;
      r_v0   <= 1'b0;
      r_v1   <= 1'b0;
      r_rr   <= 1'b0;
      r_cnt0 <= 8'd0;
      r_cnt1 <= 8'd0;
    end else begin
      if (w_acc0) begin
        r_z0 <= d0;
        r_v0 <= 1'b1;
      end else if (w_drain0) begin
        r_v0 <= 1'b0;
      end

      if (w_acc1) begin
        r_z1 <= d0;
        r_v1 <= 1'b1;
      end else if (w_drain1) begin
        r_v1 <= 1'b0;
      end

      if (mode && (w_acc0 || w_acc1)) begin
        r_rr <= ~r_rr;
      end

      if (w_drain0) begin
        r_cnt0 <= r_cnt0 + 8'd1;
      end
      if (w_drain1) begin
        r_cnt1 <= r_cnt1 + 8'd1;
      end
    end
  end

  assign d0_ready = w_ready;
  assign z0       = r_z0;
  assign z1       = r_z1;
  assign z0_valid = r_v0;
  assign z1_valid = r_v1;
  assign cnt0     = r_cnt0;
  assign cnt1     = r_cnt1;

endmodule

`default_nettype wire

// File: tb/tb_dmux2_stream.sv
//------------------------------------------------------------------------------
// Module      : tb_dmux2_stream
// Description : Directed self-checking bench for dmux2_stream.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_dmux2_stream;

  localparam int W = 8;

  logic         clk;
  logic         rstn;
  logic         mode;
  logic         s0;
  logic [W-1:0] d0;
  logic         d0_valid;
  logic         d0_ready;
  logic [W-1:0] z0;
  logic [W-1:0] z1;
  logic         z0_valid;
  logic         z1_valid;
  logic         z0_ready;
  logic         z1_ready;
  logic [7:0]   cnt0;
  logic [7:0]   cnt1;

  int n_vec;
  int n_err;

  dmux2_stream #(.W(W)) u_dut (
    .clk      (clk),
    .rstn     (rstn),
    .mode     (mode),
    .s0       (s0),
    .d0       (d0),
    .d0_valid (d0_valid),
    .d0_ready (d0_ready),
    .z0       (z0),
    .z1       (z1),
    .z0_valid (z0_valid),
    .z1_valid (z1_valid),
    .z0_ready (z0_ready),
    .z1_ready (z1_ready),
    .cnt0     (cnt0),
    .cnt1     (cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec    = 0;
    n_err    = 0;
    rstn     = 1'b0;
    mode     = 1'($urandom);
    s0       = 1'($urandom);
    d0       = 8'($urandom);
    d0_valid = 1'($urandom);
    z0_ready = 1'($urandom);
    z1_ready = 1'($urandom);

    // Reset with random inputs
    tick();
    d0 = 8'($urandom);
    s0 = 1'($urandom);
    tick();
    check("rst_z0", z0, 0);
    check("rst_z1", z1, 0);
    check("rst_z0_valid", z0_valid, 0);
    check("rst_z1_valid", z1_valid, 0);
    check("rst_cnt0", cnt0, 0);
    check("rst_cnt1", cnt1, 0);
    rstn = 1'b1; mode = 1'b0; d0_valid = 1'b0; z0_ready = 1'b1; z1_ready = 1'b1;
    #1;
    check("rst_d0_ready", d0_ready, 1);

    // Steered traffic
    d0 = 8'hA1; s0 = 1'b0; d0_valid = 1'b1;
    tick();
    check("st_z0", z0, 8'hA1);
    check("st_z0_valid", z0_valid, 1);
    d0 = 8'hB2; s0 = 1'b1;
    tick();
    check("st_z1", z1, 8'hB2);
    check("st_z1_valid", z1_valid, 1);
    check("st_z0_drained", z0_valid, 0);
    check("st_cnt0", cnt0, 1);
    d0_valid = 1'b0;
    tick();
    check("st_cnt1", cnt1, 1);
    check("st_z1_drained", z1_valid, 0);

    // Back-pressure on channel 0
    z0_ready = 1'b0;
    d0 = 8'h11; s0 = 1'b0; d0_valid = 1'b1;
    tick();
    check("bp_z0_first", z0, 8'h11);
    d0 = 8'h22;
    #1;
    check("bp_blocked", d0_ready, 0);
    tick();
    check("bp_z0_hold", z0, 8'h11);
    check("bp_z0_valid_hold", z0_valid, 1);
    d0 = 8'h33; s0 = 1'b1;
    #1;
    check("bp_no_hol", d0_ready, 1);
    tick();
    check("bp_z1", z1, 8'h33);
    check("bp_z0_still", z0, 8'h11);
    d0 = 8'h22; s0 = 1'b0; z0_ready = 1'b1;
    #1;
    check("bp_release_ready", d0_ready, 1);
    tick();
    check("bp_z0_refill", z0, 8'h22);
    check("bp_z0_valid", z0_valid, 1);
    check("bp_cnt0", cnt0, 2);
    check("bp_cnt1", cnt1, 2);
    d0_valid = 1'b0;
    tick();
    check("bp_cnt0_final", cnt0, 3);

    // Round-robin, six back-to-back words
    mode = 1'b1; d0_valid = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      d0 = 8'(i);
      s0 = 1'($urandom);
      #1;
      check("rr_ready", d0_ready, 1);
      tick();
      if (i % 2 == 1) begin
        check("rr_z0", z0, i);
        check("rr_z0_valid", z0_valid, 1);
      end else begin
        check("rr_z1", z1, i);
        check("rr_z1_valid", z1_valid, 1);
      end
    end
    d0_valid = 1'b0;
    tick();
    check("rr_cnt0", cnt0, 6);
    check("rr_cnt1", cnt1, 5);
    d0 = 8'h77; s0 = 1'b1; d0_valid = 1'b1;
    tick();
    check("rr_ptr_end_z0", z0, 8'h77);
    check("rr_ptr_end_valid", z0_valid, 1);
    d0_valid = 1'b0;
    tick();

    // Counter wrap from a clean reset
    rstn = 1'b0;
    tick();
    rstn = 1'b1; mode = 1'b0; s0 = 1'b0; d0_valid = 1'b1;
    for (int i = 0; i < 255; i++) begin
      d0 = 8'(i);
      #1;
      if (!d0_ready) check("wr_ready", d0_ready, 1);
      tick();
    end
    d0_valid = 1'b0;
    tick();
    check("wr_cnt0_255", cnt0, 255);
    d0 = 8'hEE; d0_valid = 1'b1;
    tick();
    d0 = 8'h44; s0 = 1'b1;
    tick();
    check("wr_cnt0_wrap", cnt0, 0);
    d0_valid = 1'b0;
    tick();
    check("wr_cnt1", cnt1, 1);

    // Mid-run reset with both slots full
    z0_ready = 1'b0; z1_ready = 1'b0;
    d0 = 8'h5A; s0 = 1'b0; d0_valid = 1'b1;
    tick();
    d0 = 8'hA5; s0 = 1'b1;
    tick();
    check("mr_full0", z0_valid, 1);
    check("mr_full1", z1_valid, 1);
    d0_valid = 1'b0; rstn = 1'b0;
    tick();
    check("mr_v0", z0_valid, 0);
    check("mr_v1", z1_valid, 0);
    check("mr_z0", z0, 0);
    check("mr_cnt1", cnt1, 0);
    rstn = 1'b1; z0_ready = 1'b1; z1_ready = 1'b1;
    tick();
    tick();
    check("mr_post_v0", z0_valid, 0);
    check("mr_post_v1", z1_valid, 0);
    check("mr_post_cnt0", cnt0, 0);
    check("mr_post_cnt1", cnt1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
